// File: rtl/vga_sync_gen.sv
// Free-running VGA raster generator: counters, registered sync/active decode, and a DELAY-stage delay line on sync/active.
// Latency: raw flags align with horizPos/vertPos; hsync/vsync/active lag by DELAY cycles. There is no handshake or backpressure.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 24,
    parameter int unsigned H_SYNC    = 40,
    parameter int unsigned H_BACK    = 128,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 9,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 28,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned DELAY     = 0
) (
    input  logic       video_clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] horizPos,
    output logic [9:0] vertPos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || DELAY > 7) begin : g_bad_params
        $error("vga_sync_gen: totals must be <= 1024 and DELAY <= 7");
    end

    localparam logic [9:0]  L_HLAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  L_VLAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] L_HVIS  = 11'(H_VISIBLE);
    localparam logic [10:0] L_HS0   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] L_HS1   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] L_VVIS  = 11'(V_VISIBLE);
    localparam logic [10:0] L_VS0   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] L_VS1   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [2:0]  L_IDLE  = {~H_POL, ~V_POL, 1'b0};

    logic [9:0] r_h, r_v;
    logic [9:0] w_h_nxt, w_v_nxt;
    logic       r_hs, r_vs, r_act, r_ls, r_fs;
    logic [7:0] r_fc;
    logic       w_hs_raw, w_vs_raw, w_act_raw;

    always_comb begin
        w_h_nxt = (r_h == L_HLAST) ? 10'd0 : r_h + 10'd1;
        w_v_nxt = r_v;
        if (r_h == L_HLAST) begin
            w_v_nxt = (r_v == L_VLAST) ? 10'd0 : r_v + 10'd1;
        end
    end

    // Decode from the next counter value so the registered flags line up with the counters.
    always_comb begin
        w_act_raw = ({1'b0, w_h_nxt} < L_HVIS) && ({1'b0, w_v_nxt} < L_VVIS);
        w_hs_raw  = ({1'b0, w_h_nxt} >= L_HS0) && ({1'b0, w_h_nxt} < L_HS1);
        w_vs_raw  = ({1'b0, w_v_nxt} >= L_VS0) && ({1'b0, w_v_nxt} < L_VS1);
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            r_h   <= L_HLAST;
            r_v   <= L_VLAST;
            r_hs  <= ~H_POL;
            r_vs  <= ~V_POL;
            r_act <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
            r_fc  <= 8'd0;
        end else begin
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_hs  <= w_hs_raw ? H_POL : ~H_POL;
            r_vs  <= w_vs_raw ? V_POL : ~V_POL;
            r_act <= w_act_raw;
            r_ls  <= (w_h_nxt == 10'd0);
            r_fs  <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
            if ((w_h_nxt == 10'd0) && (w_v_nxt == 10'd0)) begin
                r_fc <= r_fc + 8'd1;
            end
        end
    end

    assign horizPos    = r_h;
    assign vertPos     = r_v;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_count = r_fc;

    if (DELAY == 0) begin : g_nodly
        assign hsync  = r_hs;
        assign vsync  = r_vs;
        assign active = r_act;
    end else begin : g_dly
        logic [2:0] r_pipe [DELAY];

        // Every stage resets to idle levels so nothing stale leaks out after reset.
        always_ff @(posedge video_clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < int'(DELAY); i++) r_pipe[i] <= L_IDLE;
            end else begin
                r_pipe[0] <= {r_hs, r_vs, r_act};
                for (int i = 1; i < int'(DELAY); i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign {hsync, vsync, active} = r_pipe[DELAY-1];
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus two small-raster instances (DELAY=3, and inverted polarity).
module tb_vga_sync_gen;

    // Small raster: H 8+2+2+3 = 15, V 6+1+2+2 = 11, frame = 165 cycles.
    localparam int S_HV = 8, S_HF = 2, S_HS = 2, S_HB = 3;
    localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_HT = 15, S_VT = 11, S_FRAME = 165;

    logic video_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 video_clk = ~video_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       d_hsync, d_vsync, d_active, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       s_hsync, s_vsync, s_active, s_ls, s_fs;
    logic [9:0] s_h, s_v;
    logic [7:0] s_fc;
    logic       p_hsync, p_vsync, p_active, p_ls, p_fs;
    logic [9:0] p_h, p_v;
    logic [7:0] p_fc;

    vga_sync_gen u_def (
        .video_clk(video_clk), .reset(reset), .hsync(d_hsync), .vsync(d_vsync),
        .active(d_active), .horizPos(d_h), .vertPos(d_v), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .H_POL(1'b0), .V_POL(1'b0), .DELAY(3)
    ) u_sm (
        .video_clk(video_clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
        .active(s_active), .horizPos(s_h), .vertPos(s_v), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(0)
    ) u_pol (
        .video_clk(video_clk), .reset(reset), .hsync(p_hsync), .vsync(p_vsync),
        .active(p_active), .horizPos(p_h), .vertPos(p_v), .line_start(p_ls),
        .frame_start(p_fs), .frame_count(p_fc)
    );

    // Expected undelayed {hsync, vsync, active} for the small raster at (h, v).
    function automatic logic [2:0] exp_raw(input int h, input int v, input bit hp, input bit vp);
        logic hs, vs, act;
        hs  = (h >= S_HV + S_HF && h < S_HV + S_HF + S_HS) ? hp : ~hp;
        vs  = (v >= S_VV + S_VF && v < S_VV + S_VF + S_VS) ? vp : ~vp;
        act = (h < S_HV) && (v < S_VV);
        return {hs, vs, act};
    endfunction

    // Leaves reset low at a falling edge; the next rising edge is the first one out of reset.
    task automatic do_reset();
        @(negedge video_clk);
        reset = 1'b1;
        @(negedge video_clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge video_clk);
        n_tests++; if (d_h !== 10'd831) begin n_fail++; $display("FAIL reset_h got %0d want 831", d_h); end
        n_tests++; if (d_v !== 10'd519) begin n_fail++; $display("FAIL reset_v got %0d want 519", d_v); end
        n_tests++; if ({d_hsync, d_vsync, d_active} !== 3'b110) begin n_fail++; $display("FAIL reset_sync got %b want 110", {d_hsync, d_vsync, d_active}); end
        n_tests++; if ({d_ls, d_fs, d_fc} !== 10'd0) begin n_fail++; $display("FAIL reset_pulses got ls=%b fs=%b fc=%0d want 0", d_ls, d_fs, d_fc); end
        n_tests++; if ({p_hsync, p_vsync} !== 2'b00) begin n_fail++; $display("FAIL reset_pol got %b want 00", {p_hsync, p_vsync}); end
        reset = 1'b0;
        @(negedge video_clk);
        n_tests++; if (d_h !== 10'd0 || d_v !== 10'd0) begin n_fail++; $display("FAIL first_pos got (%0d,%0d) want (0,0)", d_h, d_v); end
        n_tests++; if ({d_ls, d_fs, d_active} !== 3'b111) begin n_fail++; $display("FAIL first_flags got ls,fs,act=%b want 111", {d_ls, d_fs, d_active}); end
        n_tests++; if (d_fc !== 8'd1) begin n_fail++; $display("FAIL first_fc got %0d want 1", d_fc); end
        n_tests++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL first_dly_active got %b want 0", s_active); end
    endtask

    task automatic test_hline();
        int hs_cnt, act_cnt, ls_cnt, pos_err, hs_first, hs_last;
        hs_cnt = 0; act_cnt = 0; ls_cnt = 0; pos_err = 0; hs_first = -1; hs_last = -1;
        do_reset();
        for (int i = 0; i < 832; i++) begin
            @(negedge video_clk);
            if (d_h !== 10'(i) || d_v !== 10'd0) pos_err++;
            if (d_hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_active === 1'b1) act_cnt++;
            if (d_ls === 1'b1) ls_cnt++;
        end
        n_tests++; if (pos_err != 0) begin n_fail++; $display("FAIL hline_pos got %0d bad cycles want 0", pos_err); end
        n_tests++; if (hs_cnt != 40) begin n_fail++; $display("FAIL hline_hs_width got %0d want 40", hs_cnt); end
        n_tests++; if (hs_first != 664 || hs_last != 703) begin n_fail++; $display("FAIL hline_hs_window got %0d..%0d want 664..703", hs_first, hs_last); end
        n_tests++; if (act_cnt != 640) begin n_fail++; $display("FAIL hline_active got %0d want 640", act_cnt); end
        n_tests++; if (ls_cnt != 1) begin n_fail++; $display("FAIL hline_ls_count got %0d want 1", ls_cnt); end
        @(negedge video_clk);
        n_tests++; if (d_h !== 10'd0 || d_v !== 10'd1 || d_ls !== 1'b1 || d_fs !== 1'b0) begin
            n_fail++; $display("FAIL hline_wrap got (%0d,%0d) ls=%b fs=%b want (0,1) ls=1 fs=0", d_h, d_v, d_ls, d_fs);
        end
    endtask

    task automatic test_frame_pol();
        int vs_cnt, hs_cnt, act_cnt, ls_cnt, fs_cnt, fs_last, fs_gap, vs_first_v;
        vs_cnt = 0; hs_cnt = 0; act_cnt = 0; ls_cnt = 0; fs_cnt = 0; fs_last = -1; fs_gap = -1; vs_first_v = -1;
        do_reset();
        for (int c = 1; c <= 2 * S_FRAME; c++) begin
            @(negedge video_clk);
            if (c == 1) begin
                n_tests++; if ({p_hsync, p_vsync} !== 2'b00) begin n_fail++; $display("FAIL pol_idle got %b want 00", {p_hsync, p_vsync}); end
            end
            if (p_vsync === 1'b1) begin
                vs_cnt++;
                if (vs_first_v < 0 && p_h === 10'd0) vs_first_v = int'(p_v);
            end
            if (p_hsync === 1'b1) hs_cnt++;
            if (p_active === 1'b1) act_cnt++;
            if (p_ls === 1'b1) ls_cnt++;
            if (p_fs === 1'b1) begin
                fs_cnt++;
                if (fs_last >= 0) fs_gap = c - fs_last;
                fs_last = c;
            end
        end
        n_tests++; if (vs_cnt != 2 * S_VS * S_HT) begin n_fail++; $display("FAIL frame_vs_cycles got %0d want %0d", vs_cnt, 2 * S_VS * S_HT); end
        n_tests++; if (vs_first_v != S_VV + S_VF) begin n_fail++; $display("FAIL frame_vs_start got line %0d want %0d", vs_first_v, S_VV + S_VF); end
        n_tests++; if (hs_cnt != 2 * S_HS * S_VT) begin n_fail++; $display("FAIL frame_hs_cycles got %0d want %0d", hs_cnt, 2 * S_HS * S_VT); end
        n_tests++; if (act_cnt != 2 * S_HV * S_VV) begin n_fail++; $display("FAIL frame_active got %0d want %0d", act_cnt, 2 * S_HV * S_VV); end
        n_tests++; if (ls_cnt != 2 * S_VT) begin n_fail++; $display("FAIL frame_ls_count got %0d want %0d", ls_cnt, 2 * S_VT); end
        n_tests++; if (fs_cnt != 2 || fs_gap != S_FRAME) begin n_fail++; $display("FAIL frame_fs got count %0d gap %0d want 2 gap %0d", fs_cnt, fs_gap, S_FRAME); end
    endtask

    task automatic test_delay();
        logic [2:0] sb_q[$];
        logic [2:0] exp_o;
        int mh, mv, first_act, first_hs, first_act_v;
        do_reset();
        sb_q.delete();
        repeat (3) sb_q.push_back(3'b110);
        mh = 0; mv = 0; first_act = -1; first_hs = -1; first_act_v = -1;
        for (int c = 0; c < 2 * S_FRAME; c++) begin
            @(negedge video_clk);
            sb_q.push_back(exp_raw(mh, mv, 1'b0, 1'b0));
            exp_o = sb_q.pop_front();
            n_tests++; if ({s_hsync, s_vsync, s_active} !== exp_o) begin
                n_fail++; $display("FAIL delay_out cycle %0d got %b want %b", c, {s_hsync, s_vsync, s_active}, exp_o);
            end
            n_tests++; if (s_h !== 10'(mh) || s_v !== 10'(mv)) begin
                n_fail++; $display("FAIL delay_pos cycle %0d got (%0d,%0d) want (%0d,%0d)", c, s_h, s_v, mh, mv);
            end
            if (first_act < 0 && s_active === 1'b1) begin first_act = int'(s_h); first_act_v = int'(s_v); end
            if (first_hs < 0 && s_hsync === 1'b0) first_hs = int'(s_h);
            mh++;
            if (mh == S_HT) begin mh = 0; mv = (mv == S_VT - 1) ? 0 : mv + 1; end
        end
        n_tests++; if (first_act != 3 || first_act_v != 0) begin n_fail++; $display("FAIL delay_active_rise got (%0d,%0d) want (3,0)", first_act, first_act_v); end
        n_tests++; if (first_hs != S_HV + S_HF + 3) begin n_fail++; $display("FAIL delay_hs_fall got h=%0d want %0d", first_hs, S_HV + S_HF + 3); end
    endtask

    task automatic test_midreset();
        do_reset();
        repeat (4 * S_HT + 6) @(negedge video_clk);
        n_tests++; if (s_h !== 10'd5 || s_v !== 10'd4 || s_active !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre got (%0d,%0d) act=%b want (5,4) act=1", s_h, s_v, s_active);
        end
        @(posedge video_clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if (s_h !== 10'(S_HT - 1) || s_v !== 10'(S_VT - 1)) begin
            n_fail++; $display("FAIL midrst_pos got (%0d,%0d) want (%0d,%0d)", s_h, s_v, S_HT - 1, S_VT - 1);
        end
        n_tests++; if ({s_hsync, s_vsync, s_active, s_ls, s_fs, s_fc} !== {5'b11000, 8'd0}) begin
            n_fail++; $display("FAIL midrst_outs got hs,vs,act,ls,fs=%b fc=%0d want 11000 fc=0", {s_hsync, s_vsync, s_active, s_ls, s_fs}, s_fc);
        end
        n_tests++; if (d_h !== 10'd831 || d_v !== 10'd519) begin n_fail++; $display("FAIL midrst_def got (%0d,%0d) want (831,519)", d_h, d_v); end
        @(negedge video_clk);
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge video_clk);
            n_tests++; if ({s_hsync, s_vsync, s_active} !== {2'b11, (c >= 4)} || s_h !== 10'(c - 1)) begin
                n_fail++; $display("FAIL midrst_restart cycle %0d got hs,vs,act=%b h=%0d want %b h=%0d",
                                   c, {s_hsync, s_vsync, s_active}, s_h, {2'b11, (c >= 4)}, c - 1);
            end
        end
    endtask

    task automatic test_wrap();
        int fs_cnt;
        fs_cnt = 0;
        do_reset();
        for (int c = 1; c <= 255 * S_FRAME; c++) begin
            @(negedge video_clk);
            if (s_fs === 1'b1) fs_cnt++;
        end
        n_tests++; if (fs_cnt != 255) begin n_fail++; $display("FAIL wrap_fs_count got %0d want 255", fs_cnt); end
        n_tests++; if (s_fc !== 8'd255 || s_h !== 10'(S_HT - 1) || s_v !== 10'(S_VT - 1)) begin
            n_fail++; $display("FAIL wrap_pre got fc=%0d (%0d,%0d) want fc=255 (%0d,%0d)", s_fc, s_h, s_v, S_HT - 1, S_VT - 1);
        end
        @(negedge video_clk);
        n_tests++; if (s_fc !== 8'd0 || s_h !== 10'd0 || s_v !== 10'd0 || s_fs !== 1'b1) begin
            n_fail++; $display("FAIL wrap_post got fc=%0d (%0d,%0d) fs=%b want fc=0 (0,0) fs=1", s_fc, s_h, s_v, s_fs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hline();
        test_frame_pol();
        test_delay();
        test_midreset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
